// File: rtl/cpu_lite_pkg.sv
// Constants and types shared by the cpu_lite core and its program-load/run sequencer.
package cpu_lite_pkg;
    localparam int ADD_WIDTH = 4;
    localparam int INSTR_W   = 8;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, CAPTURE} ctrl_state_t;
endpackage

// File: rtl/run_timer.sv
// Loadable down-counter that times the CPU RUN phase; done flags the final run cycle.
module run_timer #(
    parameter int RUN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [RUN_W-1:0] load_val,
    output logic             done
);
    logic [RUN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // cnt holds the number of run cycles left including the current one
    assign done = (cnt == RUN_W'(1));
endmodule

// File: rtl/pm_load_run_ctrl.sv
// Loads a host byte stream into cpu_lite program memory, runs the CPU for a set
// number of cycles, then captures alu_result.
module pm_load_run_ctrl #(
    parameter int ADD_WIDTH = cpu_lite_pkg::ADD_WIDTH,
    parameter int INSTR_W   = cpu_lite_pkg::INSTR_W,
    parameter int RUN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADD_WIDTH:0]   prog_len,
    input  logic [RUN_W-1:0]     run_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [INSTR_W-1:0]   s_instr,
    output logic                 pmWrEn,
    output logic [ADD_WIDTH-1:0] pm_addr,
    output logic [INSTR_W-1:0]   instructionIn,
    output logic                 cpu_run,
    input  logic [7:0]           alu_result,
    output logic [7:0]           result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 err
);
    import cpu_lite_pkg::*;

    localparam logic [ADD_WIDTH:0] DEPTH = {1'b1, {ADD_WIDTH{1'b0}}};

    ctrl_state_t        state, state_nxt;
    logic [ADD_WIDTH:0] len_q, wr_cnt, wr_cnt_nxt;
    logic [RUN_W-1:0]   run_len_q;
    logic               len_ok, start_ok, start_bad, beat, timer_done;

    assign len_ok     = (prog_len != '0) && (prog_len <= DEPTH);
    assign start_ok   = (state == IDLE) && start && !abort && len_ok;
    assign start_bad  = (state == IDLE) && start && !abort && !len_ok;
    assign beat       = (state == LOAD) && !abort && s_valid && s_ready;
    assign wr_cnt_nxt = beat ? wr_cnt + 1'b1 : wr_cnt;

    assign busy    = (state != IDLE);
    assign cpu_run = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nxt = LOAD;
                LOAD:    if (wr_cnt == len_q) state_nxt = SETTLE;
                SETTLE:  state_nxt = (run_len_q == '0) ? CAPTURE : RUN;
                RUN:     if (timer_done) state_nxt = CAPTURE;
                CAPTURE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q         <= '0;
            run_len_q     <= '0;
            wr_cnt        <= '0;
            s_ready       <= 1'b0;
            pmWrEn        <= 1'b0;
            pm_addr       <= '0;
            instructionIn <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            err           <= 1'b0;
        end else begin
            err          <= start_bad;
            pmWrEn       <= beat;
            result_valid <= (state == CAPTURE) && !abort;
            if (state == CAPTURE && !abort) begin
                result <= alu_result;
            end
            if (start_ok) begin
                len_q     <= prog_len;
                run_len_q <= run_len;
                wr_cnt    <= '0;
            end else begin
                wr_cnt <= wr_cnt_nxt;
            end
            if (beat) begin
                pm_addr       <= wr_cnt[ADD_WIDTH-1:0];
                instructionIn <= s_instr;
            end
            // ready looks one beat ahead so it drops with the last write
            case (state)
                IDLE:    s_ready <= start_ok;
                LOAD:    s_ready <= !abort && (wr_cnt_nxt < len_q);
                default: s_ready <= 1'b0;
            endcase
        end
    end

    run_timer #(.RUN_W(RUN_W)) u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == SETTLE),
        .en       (state == RUN),
        .load_val (run_len_q),
        .done     (timer_done)
    );
endmodule
